// File: rtl/clock_disp_pkg.sv
// Shared constants and types for the seven-segment display scanner.
package clock_disp_pkg;

  localparam int unsigned SEG_W = 7;
  localparam int unsigned DIG_N = 4;

  typedef logic [1:0]       dig_idx_t;
  typedef logic [SEG_W-1:0] seg_t;

  localparam seg_t SEG_ZERO  = 7'h3F;
  localparam seg_t SEG_BLANK = 7'h00;

  localparam dig_idx_t DIG_MIN_U = 2'd0;
  localparam dig_idx_t DIG_MIN_T = 2'd1;
  localparam dig_idx_t DIG_HR_U  = 2'd2;
  localparam dig_idx_t DIG_HR_T  = 2'd3;

  // One-hot digit enable for a given digit position.
  function automatic logic [DIG_N-1:0] dig_onehot(input dig_idx_t idx);
    dig_onehot = 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/disp_scan_driver_if.sv
// Bus between the clock core (master) and the display scanner (slave).
interface disp_scan_driver_if;
  import clock_disp_pkg::*;

  logic [2*SEG_W-1:0] hours_disp;
  logic [2*SEG_W-1:0] mins_disp;
  logic               AM_PM_disp;
  logic               blink_hours;
  logic               blink_mins;
  logic [DIG_N-1:0]   digit_en;
  logic [SEG_W-1:0]   seg_out;
  logic               dp_out;
  logic               frame_tick;

  modport master (
    output hours_disp, mins_disp, AM_PM_disp, blink_hours, blink_mins,
    input  digit_en, seg_out, dp_out, frame_tick
  );

  modport slave (
    input  hours_disp, mins_disp, AM_PM_disp, blink_hours, blink_mins,
    output digit_en, seg_out, dp_out, frame_tick
  );
endinterface

// File: rtl/disp_scan_timer.sv
// Slot counter, digit index and frame-end strobe for the display scanner.
module disp_scan_timer
  import clock_disp_pkg::*;
#(
  parameter  int unsigned SCAN_DIV = 1000,
  localparam int unsigned CNT_W    = $clog2(SCAN_DIV)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o,
  output dig_idx_t         idx_o,
  output logic             frame_end_c_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  dig_idx_t         idx_q, idx_d;
  logic             last_cnt_c;

  assign last_cnt_c = (cnt_q == CNT_W'(SCAN_DIV - 1));

  // Advance slot count; index steps on each slot wrap.
  always_comb begin
    cnt_d = cnt_q;
    idx_d = idx_q;
    if (en_i) begin
      if (last_cnt_c) begin
        cnt_d = '0;
        idx_d = idx_q + 2'd1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Counter state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      idx_q <= DIG_MIN_U;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
    end
  end

  assign cnt_o         = cnt_q;
  assign idx_o         = idx_q;
  assign frame_end_c_o = en_i && last_cnt_c && (idx_q == DIG_HR_T);

endmodule

// File: rtl/disp_scan_driver.sv
// Four-digit seven-segment scanner with frame-coherent input shadows,
// per-field blink and anti-ghost guard blanking.
// Optional: define DISP_LZ_BLANK_EN to blank a leading zero in hours tens.
module disp_scan_driver
  import clock_disp_pkg::*;
#(
  parameter int unsigned SCAN_DIV     = 1000,
  parameter int unsigned GUARD        = 4,
  parameter int unsigned BLINK_FRAMES = 250
) (
  input  logic              clk,
  input  logic              reset,
  disp_scan_driver_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(SCAN_DIV);
  localparam int unsigned FR_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [CNT_W-1:0] cnt_c;
  dig_idx_t         idx_c;
  logic             frame_end_c;

  logic               started_q;
  logic [2*SEG_W-1:0] sh_hours_q, sh_mins_q;
  logic               sh_pm_q, sh_bh_q, sh_bm_q;
  logic [FR_W-1:0]    fr_cnt_q, fr_cnt_d;
  logic               blink_phase_q, blink_phase_d;

  logic [DIG_N-1:0] digit_en_q, digit_en_d;
  seg_t             seg_q, seg_d;
  logic             dp_q, dp_d;
  logic             frame_tick_q, frame_tick_d;

  logic             capture_c;
  seg_t             pat_c;
  logic             field_blank_c;
  logic             lz_c;
  logic             active_c;

  disp_scan_timer #(.SCAN_DIV(SCAN_DIV)) u_timer (
    .clk          (clk),
    .reset        (reset),
    .en_i         (started_q),
    .cnt_o        (cnt_c),
    .idx_o        (idx_c),
    .frame_end_c_o(frame_end_c)
  );

  // First edge after reset only primes the shadows; scanning starts after it.
  assign capture_c = !started_q || frame_end_c;

  // Shadow capture at frame boundaries so a frame never tears.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      started_q  <= 1'b0;
      sh_hours_q <= '0;
      sh_mins_q  <= '0;
      sh_pm_q    <= 1'b0;
      sh_bh_q    <= 1'b0;
      sh_bm_q    <= 1'b0;
    end else begin
      started_q <= 1'b1;
      if (capture_c) begin
        sh_hours_q <= bus.hours_disp;
        sh_mins_q  <= bus.mins_disp;
        sh_pm_q    <= bus.AM_PM_disp;
        sh_bh_q    <= bus.blink_hours;
        sh_bm_q    <= bus.blink_mins;
      end
    end
  end

  // Blink half-period counter in frames; phase flips on wrap.
  always_comb begin
    fr_cnt_d      = fr_cnt_q;
    blink_phase_d = blink_phase_q;
    if (frame_end_c) begin
      if (fr_cnt_q == FR_W'(BLINK_FRAMES - 1)) begin
        fr_cnt_d      = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        fr_cnt_d = fr_cnt_q + FR_W'(1);
      end
    end
  end

  // Blink state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fr_cnt_q      <= '0;
      blink_phase_q <= 1'b0;
    end else begin
      fr_cnt_q      <= fr_cnt_d;
      blink_phase_q <= blink_phase_d;
    end
  end

  // Pattern of the digit currently being scanned.
  always_comb begin
    pat_c = SEG_BLANK;
    case (idx_c)
      DIG_MIN_U: pat_c = sh_mins_q[SEG_W-1:0];
      DIG_MIN_T: pat_c = sh_mins_q[2*SEG_W-1:SEG_W];
      DIG_HR_U:  pat_c = sh_hours_q[SEG_W-1:0];
      default:   pat_c = sh_hours_q[2*SEG_W-1:SEG_W];
    endcase
  end

  // Digits 2,3 belong to the hours field, digits 0,1 to minutes.
  assign field_blank_c = blink_phase_q && (idx_c[1] ? sh_bh_q : sh_bm_q);
  assign active_c      = (cnt_c >= CNT_W'(GUARD));

`ifdef DISP_LZ_BLANK_EN
  assign lz_c = (idx_c == DIG_HR_T) && (sh_hours_q[2*SEG_W-1:SEG_W] == SEG_ZERO);
`else
  assign lz_c = 1'b0;
`endif

  // Next output values; everything stays dark until scanning has started.
  always_comb begin
    digit_en_d   = '0;
    seg_d        = SEG_BLANK;
    dp_d         = 1'b0;
    frame_tick_d = 1'b0;
    if (started_q) begin
      frame_tick_d = (idx_c == DIG_MIN_U) && (cnt_c == '0);
      if (active_c) begin
        digit_en_d = dig_onehot(idx_c);
        if (!field_blank_c && !lz_c) begin
          seg_d = pat_c;
        end
        dp_d = (idx_c == DIG_MIN_U) && sh_pm_q && !field_blank_c;
      end
    end
  end

  // Output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      digit_en_q   <= '0;
      seg_q        <= SEG_BLANK;
      dp_q         <= 1'b0;
      frame_tick_q <= 1'b0;
    end else begin
      digit_en_q   <= digit_en_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign bus.digit_en   = digit_en_q;
  assign bus.seg_out    = seg_q;
  assign bus.dp_out     = dp_q;
  assign bus.frame_tick = frame_tick_q;

endmodule

// File: tb/tb_disp_scan_driver.sv
// Directed bench for disp_scan_driver (SCAN_DIV=8, GUARD=2, BLINK_FRAMES=2).
module tb_disp_scan_driver;

  localparam int unsigned SCAN_DIV     = 8;
  localparam int unsigned GUARD        = 2;
  localparam int unsigned BLINK_FRAMES = 2;

`ifdef DISP_LZ_BLANK_EN
  localparam logic [6:0] EXP_HT_ZERO = 7'h00;
`else
  localparam logic [6:0] EXP_HT_ZERO = 7'h3F;
`endif

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  disp_scan_driver_if bus ();

  disp_scan_driver #(
    .SCAN_DIV    (SCAN_DIV),
    .GUARD       (GUARD),
    .BLINK_FRAMES(BLINK_FRAMES)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_dark(input string tag);
    chk({tag, " digit_en"},   32'(bus.digit_en),   32'h0);
    chk({tag, " seg_out"},    32'(bus.seg_out),    32'h0);
    chk({tag, " dp_out"},     32'(bus.dp_out),     32'h0);
    chk({tag, " frame_tick"}, 32'(bus.frame_tick), 32'h0);
  endtask

  // Check frame positions k0..k0+n-1 (k = slot*SCAN_DIV + count), one per cycle.
  // blank_m / blank_h: whether that field is expected dark in this frame.
  task automatic check_cycles(input string tag, input int k0, input int n,
                              input logic [6:0] s0, input logic [6:0] s1,
                              input logic [6:0] s2, input logic [6:0] s3,
                              input logic pm, input logic blank_m, input logic blank_h);
    logic [6:0] s [4];
    logic [3:0] e_en;
    logic [6:0] e_seg;
    logic       e_dp;
    logic       e_ft;
    int         slot;
    int         c;
    s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
    for (int k = k0; k < k0 + n; k++) begin
      slot  = k / int'(SCAN_DIV);
      c     = k % int'(SCAN_DIV);
      e_en  = 4'h0;
      e_seg = 7'h00;
      e_dp  = 1'b0;
      e_ft  = (k == 0);
      if (c >= int'(GUARD)) begin
        e_en = 4'b0001 << slot;
        if (!((slot < 2) ? blank_m : blank_h)) e_seg = s[slot];
        e_dp = (slot == 0) && pm && !blank_m;
      end
      chk($sformatf("%s k%0d digit_en", tag, k),   32'(bus.digit_en),   32'(e_en));
      chk($sformatf("%s k%0d seg_out", tag, k),    32'(bus.seg_out),    32'(e_seg));
      chk($sformatf("%s k%0d dp_out", tag, k),     32'(bus.dp_out),     32'(e_dp));
      chk($sformatf("%s k%0d frame_tick", tag, k), 32'(bus.frame_tick), 32'(e_ft));
      tick(1);
    end
  endtask

  initial begin
    reset           = 1'b0;
    bus.hours_disp  = {7'h06, 7'h5B};
    bus.mins_disp   = {7'h4F, 7'h66};
    bus.AM_PM_disp  = 1'b1;
    bus.blink_hours = 1'b0;
    bus.blink_mins  = 1'b0;

    // Reset asserted with live inputs: outputs dark with no clock edge.
    #1 reset = 1'b1;
    #1 chk_dark("rst_async");
    tick(5);
    chk_dark("rst_hold");

    bus.AM_PM_disp = 1'b0;
    @(negedge clk) reset = 1'b0;
    tick(1);
    chk_dark("prime_edge");
    tick(1);

    // Frame 1: two guard cycles, then each digit in turn.
    check_cycles("f1", 0, 32, 7'h66, 7'h4F, 7'h5B, 7'h06, 1'b0, 1'b0, 1'b0);

    // Frame 2: minutes change mid-frame must not tear the frame.
    check_cycles("f2a", 0, 11, 7'h66, 7'h4F, 7'h5B, 7'h06, 1'b0, 1'b0, 1'b0);
    bus.mins_disp = {7'h3F, 7'h3F};
    check_cycles("f2b", 11, 21, 7'h66, 7'h4F, 7'h5B, 7'h06, 1'b0, 1'b0, 1'b0);

    // Frame 3 shows new minutes; PM and zero hours-tens arrive mid-frame.
    bus.AM_PM_disp = 1'b1;
    bus.hours_disp = {7'h3F, 7'h5B};
    check_cycles("f3", 0, 32, 7'h3F, 7'h3F, 7'h5B, 7'h06, 1'b0, 1'b0, 1'b0);

    // Frame 4: decimal point on digit 0, hours-tens zero handling.
    check_cycles("f4", 0, 32, 7'h3F, 7'h3F, 7'h5B, EXP_HT_ZERO, 1'b1, 1'b0, 1'b0);

    // Frame 5 into slot 2, then reset mid-cycle clears outputs at once.
    check_cycles("f5", 0, 19, 7'h3F, 7'h3F, 7'h5B, EXP_HT_ZERO, 1'b1, 1'b0, 1'b0);
    chk("pre_rst digit_en", 32'(bus.digit_en), 32'h4);
    #2 reset = 1'b1;
    #1 chk_dark("rst_mid");
    tick(3);
    chk_dark("rst_mid_hold");

    // Minutes blink: visible frames 1,2,5,6; dark 3,4; dp follows digit 0.
    bus.hours_disp = {7'h06, 7'h5B};
    bus.mins_disp  = {7'h4F, 7'h66};
    bus.AM_PM_disp = 1'b1;
    bus.blink_mins = 1'b1;
    @(negedge clk) reset = 1'b0;
    tick(2);
    for (int f = 1; f <= 6; f++) begin
      check_cycles($sformatf("blink_f%0d", f), 0, 32, 7'h66, 7'h4F, 7'h5B, 7'h06,
                   1'b1, (f == 3) || (f == 4), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
